// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache:
// FSM encoding, block geometry and a saturating counter helper.
package cache_pkg;
  localparam int BLOCK_BYTES    = 16;
  localparam int WORDS_PER_LINE = 4;
  localparam int WORD_W         = 32;
  localparam int LINE_W         = WORDS_PER_LINE * WORD_W;
  localparam int OFFS_W         = $clog2(BLOCK_BYTES);
  localparam int WSEL_W         = $clog2(WORDS_PER_LINE);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2
  } state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/cache_line_array.sv
// Tag/valid/dirty/data storage. Single indexed port: combinational read,
// one-word store or whole-line fill at the clock edge.
module cache_line_array
  import cache_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int IDX_W     = $clog2(NUM_LINES),
  parameter int TAG_W     = 32 - OFFS_W - IDX_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  idx_i,
  output logic              valid_o,
  output logic              dirty_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic [LINE_W-1:0] line_o,
  input  logic              word_we_i,
  input  logic [WSEL_W-1:0] word_sel_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              fill_i,
  input  logic [TAG_W-1:0]  fill_tag_i,
  input  logic [LINE_W-1:0] fill_line_i
);
  logic [NUM_LINES-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign line_o  = data_q[idx_i];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (word_we_i) begin
      dirty_q[idx_i] <= 1'b1;
    end
  end

  // Payload needs no reset; validity is carried by valid_q.
  always_ff @(posedge clk_i) begin
    if (fill_i) begin
      tag_q[idx_i]  <= fill_tag_i;
      data_q[idx_i] <= fill_line_i;
    end else if (word_we_i) begin
      data_q[idx_i][word_sel_i*WORD_W +: WORD_W] <= word_i;
    end
  end
endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with a blocking
// IDLE/WRITEBACK/ALLOCATE miss FSM and saturating hit/miss counters.
module data_cache
  import cache_pkg::*;
#(
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = cache_pkg::WORDS_PER_LINE
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_read_i,
  input  logic              cpu_write_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic [31:0]       cpu_rdata_o,
  output logic              cpu_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_ready_i,
  output logic [31:0]       hit_count_o,
  output logic [31:0]       miss_count_o
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 32 - OFFS_W - IDX_W;

  state_e            state_q, state_d;
  logic              fill_done_q;
  logic [31:0]       hit_q, miss_q;
  logic [WSEL_W-1:0] word_sel;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  req_tag, line_tag;
  logic              line_valid, line_dirty, hit, access;
  logic [LINE_W-1:0] line;
  logic              stall, req, we, word_we, fill, hit_inc, miss_inc;
  logic [31:0]       addr;
  logic              unused_addr;

  assign word_sel    = cpu_addr_i[OFFS_W-1:2];
  assign idx         = cpu_addr_i[OFFS_W +: IDX_W];
  assign req_tag     = cpu_addr_i[31 -: TAG_W];
  assign unused_addr = ^cpu_addr_i[1:0];
  assign access      = cpu_read_i | cpu_write_i;
  assign hit         = line_valid && (line_tag == req_tag);

  cache_line_array #(.NUM_LINES(NUM_LINES), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_array (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .idx_i       (idx),
    .valid_o     (line_valid),
    .dirty_o     (line_dirty),
    .tag_o       (line_tag),
    .line_o      (line),
    .word_we_i   (word_we & ~rst_i),
    .word_sel_i  (word_sel),
    .word_i      (cpu_wdata_i),
    .fill_i      (fill & ~rst_i),
    .fill_tag_i  (req_tag),
    .fill_line_i (mem_rdata_i)
  );

  always_comb begin
    state_d  = state_q;
    stall    = 1'b0;
    req      = 1'b0;
    we       = 1'b0;
    addr     = '0;
    word_we  = 1'b0;
    fill     = 1'b0;
    hit_inc  = 1'b0;
    miss_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          if (hit) begin
            word_we = cpu_write_i;
            hit_inc = ~fill_done_q;  // replayed request after a fill is not a new hit
          end else begin
            stall    = 1'b1;
            miss_inc = 1'b1;
            state_d  = (line_valid && line_dirty) ? ST_WRITEBACK : ST_ALLOCATE;
          end
        end
      end
      ST_WRITEBACK: begin
        stall = 1'b1;
        req   = 1'b1;
        we    = 1'b1;
        addr  = {line_tag, idx, {OFFS_W{1'b0}}};
        if (mem_ready_i) state_d = ST_ALLOCATE;
      end
      ST_ALLOCATE: begin
        stall = 1'b1;
        req   = 1'b1;
        addr  = {req_tag, idx, {OFFS_W{1'b0}}};
        if (mem_ready_i) begin
          fill    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      fill_done_q <= 1'b0;
      hit_q       <= '0;
      miss_q      <= '0;
    end else begin
      state_q     <= state_d;
      fill_done_q <= fill;
      if (hit_inc)  hit_q  <= sat_inc(hit_q);
      if (miss_inc) miss_q <= sat_inc(miss_q);
    end
  end

  assign cpu_rdata_o  = line[word_sel*WORD_W +: WORD_W];
  assign cpu_stall_o  = stall & ~rst_i;
  assign mem_req_o    = req & ~rst_i;
  assign mem_we_o     = we & ~rst_i;
  assign mem_addr_o   = addr;
  assign mem_wdata_o  = line;
  assign hit_count_o  = hit_q;
  assign miss_count_o = miss_q;
endmodule
